// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: data width and load-type encodings.
package wb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction and misalignment detection for the write-back stage.
// Purely combinational: picks the addressed byte/halfword, sign- or zero-extends
// it, and flags offsets that the selected load type cannot legally use.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_byte_off,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/halfword, then extend it according to the load type.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    o_data     = {DATA_W{1'b0}};
    o_misalign = 1'b0;

    case (i_byte_off)
      2'b00:   w_byte = i_data[7:0];
      2'b01:   w_byte = i_data[15:8];
      2'b10:   w_byte = i_data[23:16];
      2'b11:   w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase

    // Halfwords only live at offset 0 or 2; odd offsets are flagged below.
    if (i_byte_off[1]) begin
      w_half = i_data[31:16];
    end else begin
      w_half = i_data[15:0];
    end

    case (i_load_type)
      LD_LW: begin
        o_data     = i_data;
        o_misalign = (i_byte_off != 2'b00);
      end
      LD_LH: begin
        o_data     = {{16{w_half[15]}}, w_half};
        o_misalign = i_byte_off[0];
      end
      LD_LHU: begin
        o_data     = {16'h0000, w_half};
        o_misalign = i_byte_off[0];
      end
      LD_LB: begin
        o_data     = {{24{w_byte[7]}}, w_byte};
        o_misalign = 1'b0;
      end
      LD_LBU: begin
        o_data     = {24'h000000, w_byte};
        o_misalign = 1'b0;
      end
      default: begin
        // Reserved encodings return zero data and are always treated as errors.
        o_data     = {DATA_W{1'b0}};
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: captures the MEM-stage result, aligns load data,
// drives the register-file write port and counts retired instructions.
// Optional feature macro: WB_FWD_EN enables the forwarding-hit flags Fwd_A/Fwd_B;
// without it the flags are tied low.
module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              In_Reg_Write,
  input  logic              In_Mem_To_Reg,
  input  logic [2:0]        In_Load_Type,
  input  logic [1:0]        In_Byte_Off,
  input  logic [4:0]        In_W_Addr,
  input  logic [DATA_W-1:0] In_ALU_Result,
  input  logic [DATA_W-1:0] M_R_Data,
  input  logic [4:0]        R_Addr_A,
  input  logic [4:0]        R_Addr_B,
  output logic              Write_Reg,
  output logic [4:0]        W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              WB_Valid,
  output logic              Align_Err,
  output logic [CNT_W-1:0]  Retire_Cnt,
  output logic              Fwd_A,
  output logic              Fwd_B
);

  logic              r_valid;
  logic              r_reg_write;
  logic [4:0]        r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic              r_align_err;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic [DATA_W-1:0] w_load_data;
  logic              w_misalign;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_cap_err;
  logic              w_write_reg;

  load_align u_load_align (
    .i_load_type (In_Load_Type),
    .i_byte_off  (In_Byte_Off),
    .i_data      (M_R_Data),
    .o_data      (w_load_data),
    .o_misalign  (w_misalign)
  );

  // Choose the value to write back and decide whether the incoming load is misaligned.
  always_comb begin
    w_sel_data = In_ALU_Result;
    if (In_Mem_To_Reg) begin
      w_sel_data = w_load_data;
    end else begin
      w_sel_data = In_ALU_Result;
    end
    // Only a live load can raise an alignment error; ALU results never do.
    w_cap_err = In_Valid & In_Mem_To_Reg & w_misalign;
  end

  // Stage register: Reset beats Flush beats Stall beats a normal capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_w_addr     <= 5'd0;
      r_w_data     <= {DATA_W{1'b0}};
      r_align_err  <= 1'b0;
      r_retire_cnt <= {CNT_W{1'b0}};
    end else if (Flush) begin
      // Kill the slot; address/data are left stale since nothing can write them.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_align_err <= 1'b0;
    end else if (!Stall) begin
      r_valid     <= In_Valid;
      r_reg_write <= In_Reg_Write;
      r_w_addr    <= In_W_Addr;
      r_w_data    <= w_sel_data;
      r_align_err <= w_cap_err;
      if (In_Valid && !w_cap_err) begin
        r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Write enable is built from registered state only so it is settled well
  // before the register file writes on the falling edge; r0 is never written.
  assign w_write_reg = r_valid & r_reg_write & (r_w_addr != 5'd0) & ~r_align_err;

  assign Write_Reg  = w_write_reg;
  assign W_Addr     = r_w_addr;
  assign W_Data     = r_w_data;
  assign WB_Valid   = r_valid;
  assign Align_Err  = r_align_err;
  assign Retire_Cnt = r_retire_cnt;

`ifdef WB_FWD_EN
  assign Fwd_A = w_write_reg & (r_w_addr == R_Addr_A);
  assign Fwd_B = w_write_reg & (r_w_addr == R_Addr_B);
`else
  // Read addresses are only needed for forwarding; fold them away when it is off.
  logic w_unused_raddr;
  assign w_unused_raddr = ^{R_Addr_A, R_Addr_B};
  assign Fwd_A = 1'b0;
  assign Fwd_B = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard testbench for wb_stage: a driver pushes hand-computed expectations
// per cycle, a monitor pops and compares one cycle later.
module tb_wb_stage;

  localparam int TB_CNT_W = 4;

  logic        CLK = 1'b0;
  logic        Reset, In_Valid, Stall, Flush, In_Reg_Write, In_Mem_To_Reg;
  logic [2:0]  In_Load_Type;
  logic [1:0]  In_Byte_Off;
  logic [4:0]  In_W_Addr, R_Addr_A, R_Addr_B;
  logic [31:0] In_ALU_Result, M_R_Data;
  logic        Write_Reg, WB_Valid, Align_Err, Fwd_A, Fwd_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [TB_CNT_W-1:0] Retire_Cnt;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        dchk;
    logic        aerr;
    logic [3:0]  cnt;
    logic        fa;
    logic        fb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  wb_stage #(.CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
    .In_Reg_Write(In_Reg_Write), .In_Mem_To_Reg(In_Mem_To_Reg),
    .In_Load_Type(In_Load_Type), .In_Byte_Off(In_Byte_Off), .In_W_Addr(In_W_Addr),
    .In_ALU_Result(In_ALU_Result), .M_R_Data(M_R_Data),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .WB_Valid(WB_Valid),
    .Align_Err(Align_Err), .Retire_Cnt(Retire_Cnt), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
  task automatic step(input logic rst, stall, flush, v, rw, m2r,
                      input logic [2:0] lt, input logic [1:0] off, input logic [4:0] wa,
                      input logic [31:0] alu, mem, input logic [4:0] ra, rb,
                      input logic ev, ewr, input logic [4:0] eaddr, input logic [31:0] edata,
                      input logic edchk, eaerr, input logic [3:0] ecnt);
    exp_t e;
    @(posedge CLK);
    #2;
    Reset = rst; Stall = stall; Flush = flush; In_Valid = v; In_Reg_Write = rw;
    In_Mem_To_Reg = m2r; In_Load_Type = lt; In_Byte_Off = off; In_W_Addr = wa;
    In_ALU_Result = alu; M_R_Data = mem; R_Addr_A = ra; R_Addr_B = rb;
    e.valid = ev; e.wr = ewr; e.addr = eaddr; e.data = edata; e.dchk = edchk;
    e.aerr = eaerr; e.cnt = ecnt;
`ifdef WB_FWD_EN
    e.fa = ewr & (eaddr == ra);
    e.fb = ewr & (eaddr == rb);
`else
    e.fa = 1'b0;
    e.fb = 1'b0;
`endif
    q.push_back(e);
  endtask

  // Monitor: one cycle after each edge, compare outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("WB_Valid",   {31'd0, WB_Valid},   {31'd0, e.valid});
        chk("Write_Reg",  {31'd0, Write_Reg},  {31'd0, e.wr});
        chk("W_Addr",     {27'd0, W_Addr},     {27'd0, e.addr});
        if (e.dchk) chk("W_Data", W_Data, e.data);
        chk("Align_Err",  {31'd0, Align_Err},  {31'd0, e.aerr});
        chk("Retire_Cnt", {28'd0, Retire_Cnt}, {28'd0, e.cnt});
        chk("Fwd_A",      {31'd0, Fwd_A},      {31'd0, e.fa});
        chk("Fwd_B",      {31'd0, Fwd_B},      {31'd0, e.fb});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed stimulus. Argument order: rst stall flush v rw m2r lt off wa alu mem ra rb |
  // expected valid wr addr data dchk aerr cnt
  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; In_Valid = 1'b0; In_Reg_Write = 1'b0;
    In_Mem_To_Reg = 1'b0; In_Load_Type = 3'd0; In_Byte_Off = 2'd0; In_W_Addr = 5'd0;
    In_ALU_Result = 32'd0; M_R_Data = 32'd0; R_Addr_A = 5'd0; R_Addr_B = 5'd0;

    // Reset state
    step(1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0,2'd0,5'd0, 32'h0,32'h0, 5'd0,5'd0,
         1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,4'd0);
    // LB offset 11 -> sign-extended top byte
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd3,2'd3,5'd5, 32'h0,32'h80FF_0000, 5'd5,5'd3,
         1'b1,1'b1,5'd5,32'hFFFF_FF80,1'b1,1'b0,4'd1);
    // LHU offset 10
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd2,2'd2,5'd6, 32'h0,32'hC381_0DB0, 5'd6,5'd6,
         1'b1,1'b1,5'd6,32'h0000_C381,1'b1,1'b0,4'd2);
    // LH offset 10
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd1,2'd2,5'd6, 32'h0,32'hC381_0DB0, 5'd1,5'd6,
         1'b1,1'b1,5'd6,32'hFFFF_C381,1'b1,1'b0,4'd3);
    // LW offset 01 -> alignment error, no write, no retire
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd0,2'd1,5'd7, 32'h0,32'hDEAD_BEEF, 5'd7,5'd0,
         1'b1,1'b0,5'd7,32'hDEAD_BEEF,1'b1,1'b1,4'd3);
    // ALU write to r0 (odd offset irrelevant for ALU path): valid, no write, retires
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd1,5'd0, 32'h0000_1234,32'hFFFF_FFFF, 5'd0,5'd0,
         1'b1,1'b0,5'd0,32'h0000_1234,1'b1,1'b0,4'd4);
    // LBU offset 01
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd4,2'd1,5'd10, 32'h0,32'h0000_8000, 5'd10,5'd0,
         1'b1,1'b1,5'd10,32'h0000_0080,1'b1,1'b0,4'd5);
    // LB offset 10
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd3,2'd2,5'd11, 32'h0,32'h0080_0000, 5'd0,5'd11,
         1'b1,1'b1,5'd11,32'hFFFF_FF80,1'b1,1'b0,4'd6);
    // Reserved load type -> error
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd5,2'd0,5'd12, 32'h0,32'h1234_5678, 5'd12,5'd0,
         1'b1,1'b0,5'd12,32'h0,1'b0,1'b1,4'd6);
    // LH odd offset -> error
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd1,2'd3,5'd13, 32'h0,32'h0000_ABCD, 5'd13,5'd0,
         1'b1,1'b0,5'd13,32'h0,1'b0,1'b1,4'd6);
    // ALU write to r9
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd9, 32'h0000_0055,32'h0, 5'd9,5'd3,
         1'b1,1'b1,5'd9,32'h0000_0055,1'b1,1'b0,4'd7);
    // Stall 1: hold despite new input
    step(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd13, 32'h0000_00AA,32'h0, 5'd9,5'd3,
         1'b1,1'b1,5'd9,32'h0000_0055,1'b1,1'b0,4'd7);
    // Stall 2 with Flush: slot killed
    step(1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd13, 32'h0000_00AA,32'h0, 5'd9,5'd3,
         1'b0,1'b0,5'd9,32'h0000_0055,1'b1,1'b0,4'd7);
    // Stall 3: still empty, write never issued
    step(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd13, 32'h0000_00AA,32'h0, 5'd9,5'd3,
         1'b0,1'b0,5'd9,32'h0000_0055,1'b1,1'b0,4'd7);
    // Bubble capture
    step(1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0,2'd0,5'd0, 32'h0,32'h0, 5'd0,5'd0,
         1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,4'd7);
    // LW offset 10 -> error, then stall holds Align_Err
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 3'd0,2'd2,5'd14, 32'h0,32'h1111_1111, 5'd14,5'd0,
         1'b1,1'b0,5'd14,32'h1111_1111,1'b1,1'b1,4'd7);
    step(1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd20, 32'h0000_0099,32'h0, 5'd14,5'd0,
         1'b1,1'b0,5'd14,32'h1111_1111,1'b1,1'b1,4'd7);
    // Flush alone beats capture: no retire
    step(1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd20, 32'h0000_0099,32'h0, 5'd20,5'd0,
         1'b0,1'b0,5'd14,32'h1111_1111,1'b1,1'b0,4'd7);
    // Capture then reset during stall discards it
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd15, 32'h0000_0077,32'h0, 5'd15,5'd15,
         1'b1,1'b1,5'd15,32'h0000_0077,1'b1,1'b0,4'd8);
    step(1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0, 3'd0,2'd0,5'd15, 32'h0000_0077,32'h0, 5'd15,5'd15,
         1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,4'd0);
    // Counter wrap (4-bit counter): 17 retirements
    for (int i = 1; i <= 17; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic [3:0]  c;
      a = 5'(i);
      d = 32'(i) + 32'h0000_0100;
      c = 4'(i % 16);
      step(1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0,2'd0,a, d,32'h0, 5'd1,a,
           1'b1,1'b1,a,d,1'b1,1'b0,c);
    end
    // Final reset
    step(1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0,2'd0,5'd0, 32'h0,32'h0, 5'd0,5'd0,
         1'b0,1'b0,5'd0,32'h0,1'b1,1'b0,4'd0);

    repeat (3) @(posedge CLK);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
